// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input grant picker holding the last_gnt history.
// With MEM_ARB_FIXED_PRIO_EN defined, port 0 always wins and no history is kept.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_port,
  output logic gnt_port,
  output logic gnt_valid
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_s;
  assign unused_s = ^{clk, rst_n, upd, upd_port};

  // Port 0 wins whenever it is requesting
  always_comb begin
    gnt_port = 1'b0;
    if (req0) begin
      gnt_port = 1'b0;
    end else if (req1) begin
      gnt_port = 1'b1;
    end else begin
      gnt_port = 1'b0;
    end
  end
`else
  logic last_gnt_r;

  // Remember the port served most recently; port 1 after reset so port 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_r <= 1'b1;
    end else if (upd) begin
      last_gnt_r <= upd_port;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  // On contention the port that was not served last wins
  always_comb begin
    gnt_port = 1'b0;
    if (req0 && req1) begin
      gnt_port = ~last_gnt_r;
    end else if (req1) begin
      gnt_port = 1'b1;
    end else begin
      gnt_port = 1'b0;
    end
  end
`endif

  assign gnt_valid = req0 | req1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and issue/wait/capture sequencer for the 8x8 memory.
// Arbitration is round-robin unless MEM_ARB_FIXED_PRIO_EN is defined (fixed priority, port 0).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] m_adr,
  output logic              m_select,
  output logic              m_op,
  output logic [DATA_W-1:0] m_i,
  input  logic [DATA_W-1:0] m_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              gnt_port_r;
  logic              arb_port_s, arb_valid_s;
  logic              sel_op_s;
  logic [ADDR_W-1:0] sel_adr_s;
  logic [DATA_W-1:0] sel_dat_s;
  logic              m_select_r, m_op_r, ack0_r, ack1_r, busy_r;
  logic [ADDR_W-1:0] m_adr_r;
  logic [DATA_W-1:0] m_i_r, rdata0_r, rdata1_r;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .upd       (state_r == DONE),
    .upd_port  (gnt_port_r),
    .gnt_port  (arb_port_s),
    .gnt_valid (arb_valid_s)
  );

  // Route the winning requester's operands toward the memory-side registers
  always_comb begin
    sel_op_s  = OP_READ;
    sel_adr_s = {ADDR_W{1'b0}};
    sel_dat_s = {DATA_W{1'b0}};
    if (arb_port_s) begin
      sel_op_s  = op1;
      sel_adr_s = addr1;
      sel_dat_s = wdata1;
    end else begin
      sel_op_s  = op0;
      sel_adr_s = addr0;
      sel_dat_s = wdata0;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = arb_valid_s ? ISSUE : IDLE;
      ISSUE:   state_nx_s = WAIT;
      WAIT:    state_nx_s = (cnt_r == CNT_ZERO) ? DONE : WAIT;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, counter and all registered outputs; strobes are derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      gnt_port_r <= 1'b0;
      m_select_r <= 1'b0;
      m_op_r     <= OP_READ;
      m_adr_r    <= {ADDR_W{1'b0}};
      m_i_r      <= {DATA_W{1'b0}};
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      busy_r     <= 1'b0;
      rdata0_r   <= {DATA_W{1'b0}};
      rdata1_r   <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      m_select_r <= (state_nx_s == ISSUE);
      ack0_r     <= (state_nx_s == DONE) && !gnt_port_r;
      ack1_r     <= (state_nx_s == DONE) && gnt_port_r;
      busy_r     <= (state_nx_s != IDLE);
      case (state_r)
        IDLE: begin
          if (arb_valid_s) begin
            gnt_port_r <= arb_port_s;
            m_op_r     <= sel_op_s;
            m_adr_r    <= sel_adr_s;
            m_i_r      <= sel_dat_s;
          end
        end
        ISSUE: cnt_r <= CNT_LOAD;
        WAIT: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DONE: begin
          if (m_op_r == OP_READ) begin
            if (gnt_port_r) begin
              rdata1_r <= m_o;
            end else begin
              rdata0_r <= m_o;
            end
          end
        end
        default: cnt_r <= CNT_ZERO;
      endcase
    end
  end

  assign ack0     = ack0_r;
  assign ack1     = ack1_r;
  assign rdata0   = rdata0_r;
  assign rdata1   = rdata1_r;
  assign busy     = busy_r;
  assign m_adr    = m_adr_r;
  assign m_select = m_select_r;
  assign m_op     = m_op_r;
  assign m_i      = m_i_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: MEM_LAT=2 main instance plus MEM_LAT=1/15 instances.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, req0, req1, op0, op1, reqx;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;

  logic ack0, ack1, busy, m_select, m_op;
  logic [2:0] m_adr;
  logic [7:0] rdata0, rdata1, m_i, m_o;
  logic a_ack0, a_ack1, a_busy, a_sel, a_op, b_ack0, b_ack1, b_busy, b_sel, b_op;
  logic [2:0] a_adr, b_adr;
  logic [7:0] a_rdata0, a_rdata1, a_i, b_rdata0, b_rdata1, b_i;

  int tests = 0;
  int fails = 0;
  int sel_cnt = 0;
  int ack1_cnt = 0;
  int overlap_cnt = 0;
  int gnt_log[$];
  logic [7:0] mem [0:7];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .m_adr(m_adr), .m_select(m_select), .m_op(m_op), .m_i(m_i), .m_o(m_o)
  );

  mem_arbiter #(.MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req0(reqx), .req1(1'b0), .op0(op0), .op1(1'b0),
    .addr0(addr0), .addr1(3'd0), .wdata0(wdata0), .wdata1(8'd0),
    .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1), .busy(a_busy),
    .m_adr(a_adr), .m_select(a_sel), .m_op(a_op), .m_i(a_i), .m_o(8'h3C)
  );

  mem_arbiter #(.MEM_LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .req0(reqx), .req1(1'b0), .op0(op0), .op1(1'b0),
    .addr0(addr0), .addr1(3'd0), .wdata0(wdata0), .wdata1(8'd0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1), .busy(b_busy),
    .m_adr(b_adr), .m_select(b_sel), .m_op(b_op), .m_i(b_i), .m_o(8'h3C)
  );

  // Behavioural memory behind the main instance, plus event counters
  assign m_o = mem[m_adr];
  always @(posedge clk) begin
    if (m_select && m_op) mem[m_adr] <= m_i;
    if (m_select) sel_cnt <= sel_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
    if (ack0 && ack1) overlap_cnt <= overlap_cnt + 1;
    if (ack0) gnt_log.push_back(0);
    else if (ack1) gnt_log.push_back(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    step();
    step();
    v = {busy, ack0, ack1, m_select, m_op, m_adr, m_i, rdata0, rdata1};
    tests++;
    if (v !== 32'd0) begin fails++; $display("FAIL reset_outputs: got %h, expected 0", v); end
    v = {10'd0, a_busy, a_sel, a_op, a_adr, a_i, b_busy, b_sel, b_op, b_adr};
    tests++;
    if (v !== 32'd0) begin fails++; $display("FAIL reset_outputs_lat: got %h, expected 0", v); end
    rst_n = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_no_req: busy=%b, expected 0", busy); end
  endtask

  task automatic test_latency();
    int al1, al15, unstable;
    logic [11:0] held;
    al1 = -1; al15 = -1; unstable = 0; held = 12'd0;
    op0 = OP_READ; addr0 = 3'd6; wdata0 = 8'h77; reqx = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) begin
        held = {b_op, b_adr, b_i};
        reqx = 1'b0; op0 = OP_WRITE; addr0 = 3'd2; wdata0 = 8'h99;
      end
      if (c >= 2 && c <= 16 && {b_op, b_adr, b_i} !== held) unstable++;
      if (a_ack0 && al1 < 0) al1 = c;
      if (b_ack0 && al15 < 0) al15 = c;
    end
    tests++;
    if (held !== {1'b0, 3'd6, 8'h77}) begin fails++; $display("FAIL lat15_latched_cmd: got %h, expected 677", held); end
    tests++;
    if (unstable != 0) begin fails++; $display("FAIL lat15_hold: %0d unstable WAIT cycles, expected 0", unstable); end
    tests++;
    if (al1 != 3) begin fails++; $display("FAIL lat1_ack_cycle: got %0d, expected 3", al1); end
    tests++;
    if (al15 != 17) begin fails++; $display("FAIL lat15_ack_cycle: got %0d, expected 17", al15); end
    tests++;
    if ({a_rdata0, b_rdata0} !== 16'h3C3C) begin fails++; $display("FAIL lat_rdata: got %h, expected 3c3c", {a_rdata0, b_rdata0}); end
    tests++;
    if ({a_ack1, b_ack1, a_rdata1, b_rdata1, a_busy, b_busy} !== 20'd0) begin
      fails++; $display("FAIL lat_idle_port1: got %h, expected 0", {a_ack1, b_ack1, a_rdata1, b_rdata1, a_busy, b_busy});
    end
    op0 = OP_READ; addr0 = 3'd0; wdata0 = 8'd0;
  endtask

  task automatic test_write_read();
    int s0, a;
    s0 = sel_cnt; a = -1;
    req0 = 1'b1; op0 = OP_WRITE; addr0 = 3'd3; wdata0 = 8'hA5;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) begin
        tests++;
        if ({busy, m_select, m_op, m_adr, m_i} !== {1'b1, 1'b1, 1'b1, 3'd3, 8'hA5}) begin
          fails++; $display("FAIL write_issue: got %h, expected %h", {busy, m_select, m_op, m_adr, m_i}, {1'b1, 1'b1, 1'b1, 3'd3, 8'hA5});
        end
        req0 = 1'b0;
      end
      if (ack0 && a < 0) a = c;
    end
    tests++;
    if (a != 4) begin fails++; $display("FAIL write_ack_cycle: got %0d, expected 4", a); end
    tests++;
    if (sel_cnt - s0 != 1 || mem[3] !== 8'hA5) begin
      fails++; $display("FAIL write_select_mem: selects=%0d mem=%h, expected 1 a5", sel_cnt - s0, mem[3]);
    end
    s0 = sel_cnt; a = -1;
    req0 = 1'b1; op0 = OP_READ; addr0 = 3'd3; wdata0 = 8'hFF;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) req0 = 1'b0;
      if (ack0 && a < 0) a = c;
      if (c == 4) begin
        tests++;
        if (rdata0 !== 8'h00) begin fails++; $display("FAIL read_rdata_in_done: got %h, expected 00", rdata0); end
      end
      if (c == 5) begin
        tests++;
        if ({rdata0, rdata1} !== 16'hA500) begin fails++; $display("FAIL read_rdata: got %h, expected a500", {rdata0, rdata1}); end
      end
    end
    tests++;
    if (a != 4 || sel_cnt - s0 != 1) begin fails++; $display("FAIL read_ack_select: ack=%0d selects=%0d, expected 4 1", a, sel_cnt - s0); end
  endtask

  task automatic test_contention();
    int a0, a1;
    a0 = -1; a1 = -1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 1'b1; op0 = OP_WRITE; addr0 = 3'd1; wdata0 = 8'h11;
    req1 = 1'b1; op1 = OP_WRITE; addr1 = 3'd2; wdata1 = 8'h22;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) req0 = 1'b0;
      if (c == 6) req1 = 1'b0;
      if (ack0 && a0 < 0) a0 = c;
      if (ack1 && a1 < 0) a1 = c;
    end
    tests++;
    if (a0 != 4 || a1 != 9) begin fails++; $display("FAIL contention_ack_cycles: got %0d %0d, expected 4 9", a0, a1); end
    tests++;
    if ({mem[1], mem[2]} !== 16'h1122) begin fails++; $display("FAIL contention_mem: got %h, expected 1122", {mem[1], mem[2]}); end
  endtask

  task automatic test_sustained();
    int n, ov0, exp_g;
    n = 0; ov0 = overlap_cnt;
    gnt_log.delete();
    req0 = 1'b1; op0 = OP_READ; addr0 = 3'd1;
    req1 = 1'b1; op1 = OP_READ; addr1 = 3'd2;
    for (int c = 1; c <= 60 && n < 6; c++) begin
      step();
      if (ack0 || ack1) n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();
    tests++;
    if (n != 6 || gnt_log.size() != 6) begin fails++; $display("FAIL sustained_count: acks=%0d logged=%0d, expected 6 6", n, gnt_log.size()); end
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
      exp_g = FIXED ? 0 : (i % 2);
      tests++;
      if (gnt_log[i] != exp_g) begin fails++; $display("FAIL sustained_grant_%0d: got %0d, expected %0d", i, gnt_log[i], exp_g); end
    end
    tests++;
    if (overlap_cnt != ov0) begin fails++; $display("FAIL ack_overlap: got %0d overlaps, expected 0", overlap_cnt - ov0); end
    tests++;
    if ({rdata0, rdata1} !== {8'h11, (FIXED ? 8'h00 : 8'h22)}) begin
      fails++; $display("FAIL sustained_rdata: got %h, expected %h", {rdata0, rdata1}, {8'h11, (FIXED ? 8'h00 : 8'h22)});
    end
  endtask

  task automatic test_withdraw();
    int a;
    logic [7:0] prev;
    a = -1; prev = rdata1;
    req1 = 1'b1; op1 = OP_READ; addr1 = 3'd1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 2) req1 = 1'b0;
      if (ack1 && a < 0) a = c;
      if (c == 4) begin
        tests++;
        if (rdata1 !== prev) begin fails++; $display("FAIL withdraw_rdata_in_done: got %h, expected %h", rdata1, prev); end
      end
      if (c == 5) begin
        tests++;
        if (rdata1 !== 8'h11) begin fails++; $display("FAIL withdraw_rdata: got %h, expected 11", rdata1); end
      end
    end
    tests++;
    if (a != 4) begin fails++; $display("FAIL withdraw_ack_cycle: got %0d, expected 4", a); end
  endtask

  task automatic test_reset_wait();
    int k0, a;
    bit seen;
    logic [31:0] v;
    req1 = 1'b1; op1 = OP_WRITE; addr1 = 3'd5; wdata1 = 8'h5A;
    step();
    req1 = 1'b0;
    step();
    tests++;
    if ({busy, m_select, m_op, m_adr, m_i} !== {1'b1, 1'b0, 1'b1, 3'd5, 8'h5A}) begin
      fails++; $display("FAIL reset_wait_pre: got %h, expected %h", {busy, m_select, m_op, m_adr, m_i}, {1'b1, 1'b0, 1'b1, 3'd5, 8'h5A});
    end
    rst_n = 1'b0;
    step();
    v = {busy, ack0, ack1, m_select, m_op, m_adr, m_i, rdata0, rdata1};
    tests++;
    if (v !== 32'd0) begin fails++; $display("FAIL reset_wait_outputs: got %h, expected 0", v); end
    rst_n = 1'b1;
    k0 = ack1_cnt; seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack0 || ack1 || busy) seen = 1'b1;
    end
    tests++;
    if (seen || ack1_cnt != k0) begin fails++; $display("FAIL reset_wait_no_ack: activity=%0b acks=%0d, expected 0 0", seen, ack1_cnt - k0); end
    a = -1;
    req1 = 1'b1; op1 = OP_READ; addr1 = 3'd2;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) req1 = 1'b0;
      if (ack1 && a < 0) a = c;
    end
    tests++;
    if (a != 4 || rdata1 !== 8'h22) begin fails++; $display("FAIL reset_wait_fresh: ack=%0d rdata1=%h, expected 4 22", a, rdata1); end
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; reqx = 1'b0;
    op0 = OP_READ; op1 = OP_READ; addr0 = 3'd0; addr1 = 3'd0;
    wdata0 = 8'd0; wdata1 = 8'd0;
    test_reset();
    test_latency();
    test_write_read();
    test_contention();
    test_sustained();
    test_withdraw();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the 8x8 `memory` block. It accepts read/write requests from two independent requesters over a req/ack handshake and grants the single memory port round-robin. It drives the memory's address, select, op and data inputs through an issue/wait/capture sequence, and returns read data to the granted requester. It sits between the requester logic and `memory`, and is the only driver of the memory's control pins.

## Interface
Parameters:
- `MEM_LAT`, default 2: cycles between the `m_select` pulse and valid `m_o`. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0`, `req1` in 1: request from port 0 / port 1.
- `op0`, `op1` in 1: operation, 1 = write, 0 = read.
- `addr0`, `addr1` in 3: row address.
- `wdata0`, `wdata1` in 8: write data.
- `ack0`, `ack1` out 1: single-cycle completion pulse.
- `rdata0`, `rdata1` out 8: read data, registered.
- `busy` out 1: a transaction is in flight (state is not IDLE).
- `m_adr` out 3: to the memory address pins `adr2..adr0`.
- `m_select` out 1: to memory `select`.
- `m_op` out 1: to memory `op`.
- `m_i` out 8: to memory `i7..i0`.
- `m_o` in 8: from memory `o7..o0`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `reqN` is high, choose the winner, latch its op, addr and wdata into `m_op`, `m_adr`, `m_i`, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `m_select` = 1 for exactly this cycle. Load the wait counter with `MEM_LAT`-1, then go to WAIT.
- WAIT: `m_select` = 0. `m_adr`, `m_op`, `m_i` are held stable. Decrement the counter each cycle; at 0 go to DONE.
- DONE: pulse `ackN` of the granted port.
  - On a read, capture `m_o` into `rdataN`.
  - On a write, `rdataN` is unchanged.
  - Update `last_gnt` to the granted port, then go to IDLE.
- Arbitration:
  - If only one request is high, it wins.
  - If both are high, the port that is not `last_gnt` wins.
  - `last_gnt` resets to 1, so port 0 wins the first contention.
- Requester rules: `reqN`, `opN`, `addrN`, `wdataN` are sampled only in IDLE. They may change freely once the block has left IDLE.
- If `reqN` drops mid-transaction, the transaction still completes and `ackN` still pulses.
- If `reqN` is still high in the cycle after `ackN`, it counts as a new request. Round-robin then gives the other port priority if it is requesting.
- `rdataN` holds its value until the next read completes on that port.
- The two ack signals are never high in the same cycle.

## Timing
- A request is first seen high in IDLE at cycle 0. Then:
  - ISSUE at cycle 1.
  - WAIT for cycles 2..`MEM_LAT`+1.
  - DONE, with `ackN` high, at cycle `MEM_LAT`+2.
  - IDLE again at cycle `MEM_LAT`+3.
- Minimum spacing between transactions is therefore `MEM_LAT`+3 cycles.
- `rdataN` is valid from the cycle after DONE. It is registered on the DONE edge.
- Reset: `rst_n` low at a rising edge forces, from the next cycle:
  - state = IDLE, `last_gnt` = 1, wait counter = 0;
  - `m_select` = 0, `m_op` = 0, `m_adr` = 0, `m_i` = 0;
  - `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `busy` = 0.
- Reset during ISSUE, WAIT or DONE aborts the transaction with no ack.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: fixed priority. Port 0 always wins contention; `last_gnt` is not implemented.
- Undefined (default): round-robin as described under Operation.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE);
  - `OP_READ` = 1'b0, `OP_WRITE` = 1'b1;
  - `ADDR_W` = 3, `DATA_W` = 8.
- One sub-module, `rr_arb2`: a two-input picker with the `last_gnt` register and grant/update strobes. It is also where the fixed-priority variant is compiled.
- The top level holds the FSM, the wait counter, the memory-side output registers and the read-data capture.

## Test plan
- Single write then read, `MEM_LAT`=2: port 0 writes 0xA5 to address 3; ack0 arrives at cycle 4. Port 0 then reads address 3; `rdata0` = 0xA5 after ack0, and `m_select` is high for exactly one cycle per transaction.
- Contention after reset: `req0` and `req1` rise together. Port 0 is served first and port 1 immediately after; ack1 arrives at cycle `MEM_LAT`+3 after ack0.
- Sustained contention: both requests held high for 6 transactions. Grants alternate 0,1,0,1,0,1 and the two acks never overlap (fixed-priority build: all grants go to 0).
- Request withdrawal: `req1` drops in WAIT. ack1 still pulses in DONE, and `rdata1` updates if the op was a read.
- Reset in WAIT: `rst_n` low for one edge. All outputs are 0 next cycle with no ack. A fresh `req1` then completes normally.
- `MEM_LAT`=1 and `MEM_LAT`=15: ack arrives at cycle 3 and cycle 17 respectively, and `m_adr`, `m_op`, `m_i` stay stable across WAIT.
